// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states
// and the register word-address helper.
package irq_controller_pkg;

  localparam logic [3:0] OFS_CTRL  = 4'h0;
  localparam logic [3:0] OFS_MASK  = 4'h4;
  localparam logic [3:0] OFS_PEND  = 4'h8;
  localparam logic [3:0] OFS_CAUSE = 4'hC;

  localparam int CAUSE_VALID_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } irq_state_t;

  // Word address (addr[31:2]) of a register at base + offset.
  function automatic logic [29:0] reg_word(input logic [31:0] base, input logic [3:0] ofs);
    logic [31:0] a;
    a = base + {28'd0, ofs};
    return a[31:2];
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Peripheral bus as seen by the interrupt controller; read data is
// combinational and ORed with other peripherals outside this block.
interface irq_controller_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/irq_controller_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
module irq_prio_enc #(
  parameter int N = 2
) (
  input  logic [N-1:0] vec,
  output logic         any,
  output logic [4:0]   idx
);

  always_comb begin
    any = |vec;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-latched sources, mask/global enable, one request
// held until taken, no nesting until the kernel handler returns.
//
// state | meaning
// IDLE  | no request outstanding; waiting for an enabled pending source in user mode
// REQ   | irq_req high, waiting for the core to take the vector
// SVC   | handler running; new events latch but cannot re-request
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int          N_SRC    = 2,
  parameter logic [31:0] IRQ_BASE = 32'h40000030
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  irq_controller_if.slave  bus,
  input  logic             kernel,
  input  logic             irq_taken,
  output logic             irq_req
);

  localparam logic [29:0] W_CTRL  = reg_word(IRQ_BASE, OFS_CTRL);
  localparam logic [29:0] W_MASK  = reg_word(IRQ_BASE, OFS_MASK);
  localparam logic [29:0] W_PEND  = reg_word(IRQ_BASE, OFS_PEND);
  localparam logic [29:0] W_CAUSE = reg_word(IRQ_BASE, OFS_CAUSE);

  irq_state_t       state;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] take_hot;
  logic             gie;
  logic             kernel_q;
  logic             cause_valid;
  logic [4:0]       cause_idx;
  logic [4:0]       win;
  logic             any;
  logic             take;
  logic             hit_ctrl;
  logic             hit_mask;
  logic             hit_pend;
  logic             hit_cause;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign hit_ctrl  = (bus.addr[31:2] == W_CTRL);
  assign hit_mask  = (bus.addr[31:2] == W_MASK);
  assign hit_pend  = (bus.addr[31:2] == W_PEND);
  assign hit_cause = (bus.addr[31:2] == W_CAUSE);

  assign rise   = src & ~src_q;
  assign active = pend & mask;
  assign take   = (state == ST_REQ) && irq_taken;
  assign clr    = (bus.wr && hit_pend) ? bus.wdata[N_SRC-1:0] : '0;

  assign unused_bits = ^{bus.addr[1:0], bus.wdata};

  irq_prio_enc #(.N(N_SRC)) u_prio (
    .vec (active),
    .any (any),
    .idx (win)
  );

  always_comb begin
    take_hot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      take_hot[i] = (win == 5'(i));
    end
  end

  // New edges win over both software clears and the taken-source clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q    <= '0;
      pend     <= '0;
      mask     <= '0;
      gie      <= 1'b0;
      kernel_q <= 1'b0;
    end else begin
      src_q    <= src;
      kernel_q <= kernel;
      pend     <= (pend & ~clr & ~(take ? take_hot : '0)) | rise;
      if (bus.wr && hit_ctrl) gie  <= bus.wdata[0];
      if (bus.wr && hit_mask) mask <= bus.wdata[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      irq_req     <= 1'b0;
      cause_valid <= 1'b0;
      cause_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gie && any && !kernel) begin
            state   <= ST_REQ;
            irq_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (irq_taken) begin
            state       <= ST_SVC;
            irq_req     <= 1'b0;
            cause_valid <= 1'b1;
            cause_idx   <= win;
          end else if (!any || !gie) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
          end
        end
        ST_SVC: begin
          // Handler return is the kernel 1->0 transition.
          if (kernel_q && !kernel) begin
            state       <= ST_IDLE;
            cause_valid <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    if (bus.rd) begin
      if (hit_ctrl) rd_mux[0] = gie;
      if (hit_mask) rd_mux[N_SRC-1:0] = mask;
      if (hit_pend) rd_mux[N_SRC-1:0] = pend;
      if (hit_cause) begin
        rd_mux[CAUSE_VALID_BIT] = cause_valid;
        rd_mux[4:0]             = cause_idx;
      end
    end
  end

  assign bus.rdata = rd_mux;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: register table after reset, then hand-written
// request/take/return sequences; bus reads go through a scoreboard queue.
module tb_irq_controller;

  localparam logic [31:0] BASE  = 32'h40000030;
  localparam logic [31:0] CTRL  = BASE;
  localparam logic [31:0] MASK  = BASE + 32'h4;
  localparam logic [31:0] PEND  = BASE + 32'h8;
  localparam logic [31:0] CAUSE = BASE + 32'hC;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] src = 2'b00;
  logic       kernel = 1'b0;
  logic       irq_taken = 1'b0;
  logic       irq_req;

  irq_controller_if bus_if ();

  irq_controller #(.N_SRC(2), .IRQ_BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .src       (src),
    .bus       (bus_if.slave),
    .kernel    (kernel),
    .irq_taken (irq_taken),
    .irq_req   (irq_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    bit          chk;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got no entry expected one");
    end else begin
      e = sb_q.pop_front();
      check(e.name, bus_if.rdata, e.exp);
    end
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus_if.rd   = 1'b1;
    bus_if.addr = addr;
    sb_q.push_back('{name, exp});
    #1;
    pop_check();
    bus_if.rd = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_if.wr    = 1'b1;
    bus_if.addr  = addr;
    bus_if.wdata = data;
    tick();
    bus_if.wr = 1'b0;
  endtask

  task automatic req_chk(input string name, input logic exp);
    check(name, {31'd0, irq_req}, {31'd0, exp});
  endtask

  task automatic add(input string n, input logic w, input logic r, input bit c,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    vecs.push_back('{n, w, r, c, a, d, e});
  endtask

  initial begin
    bus_if.rd    = 1'b0;
    bus_if.wr    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;

    add("rst_ctrl",    0, 1, 1, CTRL,  32'h0,        32'h0);
    add("rst_mask",    0, 1, 1, MASK,  32'h0,        32'h0);
    add("rst_pend",    0, 1, 1, PEND,  32'h0,        32'h0);
    add("rst_cause",   0, 1, 1, CAUSE, 32'h0,        32'h0);
    add("wr_ctrl",     1, 0, 0, CTRL,  32'hFFFFFFFF, 32'h0);
    add("ctrl_gie",    0, 1, 1, CTRL,  32'h0,        32'h1);
    add("wr_mask",     1, 0, 0, MASK,  32'hFFFFFFFF, 32'h0);
    add("mask_width",  0, 1, 1, MASK,  32'h0,        32'h3);
    add("miss_addr",   0, 1, 1, 32'h40000040, 32'h0, 32'h0);
    add("no_rd",       0, 0, 1, CTRL,  32'h0,        32'h0);
    add("wr_cause",    1, 0, 0, CAUSE, 32'hFFFFFFFF, 32'h0);
    add("cause_ro",    0, 1, 1, CAUSE, 32'h0,        32'h0);
    add("low_bits",    0, 1, 1, 32'h40000033, 32'h0, 32'h1);
    add("clr_ctrl",    1, 0, 0, CTRL,  32'h0,        32'h0);
    add("ctrl_off",    0, 1, 1, CTRL,  32'h0,        32'h0);
    add("below_base",  0, 1, 1, 32'h4000002C, 32'h0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    req_chk("rst_irq_req", 1'b0);
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      bus_if.wr    = vecs[i].wr;
      bus_if.rd    = vecs[i].rd;
      bus_if.addr  = vecs[i].addr;
      bus_if.wdata = vecs[i].wdata;
      if (vecs[i].chk) sb_q.push_back('{vecs[i].name, vecs[i].exp});
      #1;
      if (vecs[i].chk) pop_check();
      tick();
      bus_if.wr = 1'b0;
      bus_if.rd = 1'b0;
    end

    // Basic request latency: event at edge E -> pend after E, irq_req after E+1.
    bus_write(CTRL, 32'h1);
    src = 2'b01;
    tick();
    read_chk("t1_pend", PEND, 32'h1);
    req_chk("t1_req_latency", 1'b0);
    tick();
    req_chk("t1_req", 1'b1);

    // Take and return.
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    kernel = 1'b1;
    src = 2'b00;
    req_chk("t2_req_drop", 1'b0);
    read_chk("t2_cause", CAUSE, 32'h80000000);
    read_chk("t2_pend", PEND, 32'h0);
    tick();
    tick();
    kernel = 1'b0;
    tick();
    read_chk("t2_cause_ret", CAUSE, 32'h00000000);

    // Simultaneous sources: priority order.
    src = 2'b11;
    tick();
    tick();
    req_chk("t3_req", 1'b1);
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    kernel = 1'b1;
    read_chk("t3_cause0", CAUSE, 32'h80000000);
    read_chk("t3_pend_left", PEND, 32'h2);
    tick();
    kernel = 1'b0;
    tick();
    tick();
    req_chk("t3_rereq", 1'b1);
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    kernel = 1'b1;
    read_chk("t3_cause1", CAUSE, 32'h80000001);
    read_chk("t3_pend_empty", PEND, 32'h0);

    // No nesting while in SVC; re-request one cycle after return.
    src = 2'b00;
    tick();
    src = 2'b10;
    tick();
    read_chk("t4_pend_svc", PEND, 32'h2);
    tick();
    req_chk("t4_no_nest", 1'b0);
    kernel = 1'b0;
    tick();
    req_chk("t4_idle", 1'b0);
    tick();
    req_chk("t4_b2b", 1'b1);

    // Software clear of the pending bit withdraws the request.
    bus_write(PEND, 32'h2);
    read_chk("t5_pend_clr", PEND, 32'h0);
    tick();
    req_chk("t5_withdraw", 1'b0);

    // Set and clear on the same edge: set wins.
    src = 2'b00;
    tick();
    src = 2'b01;
    bus_write(PEND, 32'h1);
    read_chk("t5_set_wins", PEND, 32'h1);
    tick();
    req_chk("t5_req_again", 1'b1);

    // Dropping gie withdraws the request but leaves pend.
    bus_write(CTRL, 32'h0);
    tick();
    req_chk("t5_gie_off", 1'b0);
    read_chk("t5_pend_kept", PEND, 32'h1);

    // Async reset while servicing.
    bus_write(CTRL, 32'h1);
    tick();
    req_chk("t6_req", 1'b1);
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    kernel = 1'b1;
    read_chk("t6_cause_svc", CAUSE, 32'h80000000);
    src = 2'b11;
    tick();
    #2;
    reset = 1'b0;
    #1;
    req_chk("t6_rst_req", 1'b0);
    read_chk("t6_rst_ctrl", CTRL, 32'h0);
    read_chk("t6_rst_mask", MASK, 32'h0);
    read_chk("t6_rst_pend", PEND, 32'h0);
    read_chk("t6_rst_cause", CAUSE, 32'h0);
    kernel = 1'b0;
    reset = 1'b1;
    tick();
    read_chk("t6_held_src", PEND, 32'h3);
    tick();
    read_chk("t6_one_event", PEND, 32'h3);
    req_chk("t6_masked", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
